// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and frame constants for the sync_fifo-draining byte serializer.
// FIFO_SERIAL_TX_PARITY_EN adds the PARITY state and lengthens the frame to 11 bits.
package fifo_serial_tx_pkg;

`ifdef FIFO_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam int FRAME_BITS = 10;
`endif

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial-side status of the serializer, bundled as one port.
// master is the serializer view; slave is the FIFO/line-monitor view.
interface fifo_serial_tx_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy,
    input  tx_done
  );

endinterface

// File: rtl/fifo_serial_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_end high on the last cycle of each bit.
// clear holds the count at zero so the first bit after it gets a full period.
module tx_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one byte from sync_fifo when idle and sends start/8 data LSB-first/[parity]/stop.
// Start bit 3 cycles after IDLE sees non-empty; FIFO is only popped between frames (FIFO_SERIAL_TX_PARITY_EN adds parity).
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_serial_tx_if.master        bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   shift_nxt;
  logic [2:0]             bit_cnt;
  logic [2:0]             bit_cnt_nxt;
  logic                   tx_q;
  logic                   tx_nxt;
  logic                   done_q;
  logic                   done_nxt;
  logic                   bit_end;
  logic                   baud_clear;

  // Baud timer is held in reset until the start bit so every bit is a full period.
  assign baud_clear = (state == IDLE) || (state == REQ) || (state == LOAD);

  tx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (state == LOAD) begin
      par <= ^bus.fifo_data;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    tx_nxt      = STOP_BIT;

    case (state)
      IDLE: begin
        if (!bus.fifo_empty) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = START;
        shift_nxt = bus.fifo_data;
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shift_nxt   = shift >> 1;
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Line level is decided from the state being entered so tx can be a plain flop.
    case (state_nxt)
      START:   tx_nxt = START_BIT;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY:  tx_nxt = par;
`endif
      default: tx_nxt = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= 3'd0;
      tx_q    <= STOP_BIT;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_q    <= tx_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.fifo_rd = (state == REQ);
  assign bus.busy    = (state != IDLE);
  assign bus.tx      = tx_q;
  assign bus.tx_done = done_q;

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Byte serializer that sits directly downstream of `sync_fifo` and drains it. When the FIFO reports non-empty and the serializer is idle, it pops one byte and transmits it on a single-wire asynchronous serial line. The frame is a start bit, eight data bits LSB first, an optional parity bit and a stop bit. It is the consumer end of the write → `sync_fifo` → serial-out path.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal values are ≥2.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `fifo_empty` input 1: `empty` flag from `sync_fifo`.
- `fifo_data` input 8: `data_out` from `sync_fifo`; valid on the cycle after the edge that sampled `fifo_rd=1`.
- `fifo_rd` output 1: pop strobe to `sync_fifo` `rd`; exactly one cycle wide per byte.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high whenever state ≠ IDLE.
- `tx_done` output 1: one-cycle pulse after each completed stop bit.

## Operation
- FSM states are IDLE, REQ, LOAD, START, DATA, PARITY (only with `PARITY_EN`) and STOP.
- IDLE → REQ when `fifo_empty=0`; otherwise stay in IDLE. Never pop while `fifo_empty=1`.
- REQ lasts one cycle. `fifo_rd` is decoded as `state==REQ` and is high only in REQ.
- LOAD lasts one cycle. `fifo_data` is captured into the 8-bit shift register at the end of LOAD. The next state is START.
- START drives `tx=0` for `CLKS_PER_BIT` cycles.
- DATA sends `shift[0]` then shifts right, holding each bit `CLKS_PER_BIT` cycles. A 3-bit counter counts 0..7, after which the FSM goes to PARITY or STOP.
- PARITY drives `tx` with the even-parity bit (XOR of the 8 data bits latched at LOAD) for `CLKS_PER_BIT` cycles.
- STOP drives `tx=1` for `CLKS_PER_BIT` cycles, then goes to IDLE and asserts `tx_done` for exactly one cycle, the first IDLE cycle.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. It is cleared on entering START.
- `tx` is a registered output so it is glitch-free. It is 1 in IDLE, REQ and LOAD.
- A `fifo_empty` change in the middle of a frame is ignored; the flag is sampled in IDLE only.

## Timing
- Reset values: `tx=1`, `fifo_rd=0`, `busy=0`, `tx_done=0`, state IDLE, all counters 0.
- Reset mid-operation: all registers return to reset values at the sampling edge and the frame is abandoned. If reset hits in LOAD or later, the popped byte is lost; this is accepted. No `tx_done` is produced for an aborted frame.
- Latency:
  - Cycle 0: IDLE with `fifo_empty=0`.
  - Cycle 1: `fifo_rd=1`.
  - Cycle 2: LOAD.
  - Cycle 3: `tx` falls (start bit).
- Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back bytes: the inter-frame `tx`-high gap after the stop bit is exactly 3 cycles (IDLE, REQ, LOAD).
- `busy` rises in cycle 1 and falls together with the `tx_done` pulse.

## Configuration
- `FIFO_SERIAL_TX_PARITY_EN` defined: the PARITY state is present, an even-parity bit is sent between bit 7 and the stop bit, and a frame is 11 bits.
- `FIFO_SERIAL_TX_PARITY_EN` not defined: the PARITY state and the parity logic are absent. DATA goes directly to STOP and a frame is 10 bits.

## Structure
- Package `fifo_serial_tx_pkg` holds:
  - the state enum;
  - `START_BIT=1'b0` and `STOP_BIT=1'b1`;
  - `DATA_BITS=8`;
  - the frame-length constant, conditioned on the macro.
- Sub-module `tx_baud_counter` (parameter `CLKS_PER_BIT`) has inputs `clk`, `rst` and `clear`, and outputs a `bit_end` pulse on the last cycle of each bit. Its counter width is `$clog2(CLKS_PER_BIT)`.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- Reset: hold `rst` for 3 cycles with `fifo_empty=0` → `tx=1`, `fifo_rd=0`, `busy=0`, `tx_done=0` throughout.
- Single byte 0xA5, no parity: one `fifo_rd` pulse of 1 cycle; from cycle 3 `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `tx_done` pulses once 40 cycles after the start bit begins.
- Empty FIFO: `fifo_empty=1` for 100 cycles → `fifo_rd` never asserted, `tx` constant 1.
- Back-to-back bytes 0x01 then 0x80: exactly 2 `fifo_rd` pulses, two correct frames, 3-cycle high gap between them, 2 `tx_done` pulses.
- Reset asserted during DATA bit 4 → `tx=1` the next cycle and no `tx_done`. A subsequent byte 0x3C transmits correctly.
- With `FIFO_SERIAL_TX_PARITY_EN`:
  - byte 0x07 → parity bit 1, frame 44 cycles;
  - byte 0xA5 → parity bit 0.
